// File: rtl/fixed_p_div_pkg.sv
// Shared types and helpers for the signed fixed-point sequential divider.
// Holds the controller state encoding and a sign-extended absolute value.
package fixed_p_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  // Helpers work on a wide sign-extended value; callers keep the low bits.
  localparam int ABS_W = 128;

  // Magnitude as unsigned, so the most-negative input maps to 2^(w-1).
  function automatic logic [ABS_W-1:0] abs_u(
    input logic signed [ABS_W-1:0] v
  );
    logic [ABS_W-1:0] u;
    u = v;
    return v[ABS_W-1] ? (~u + ABS_W'(1)) : u;
  endfunction

endpackage

// File: rtl/fixed_p_std_udiv_core.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: start loads dividend/divisor; busy while iterating; finish on last bit.
module fixed_p_std_udiv_core #(
  parameter int WIDTH = 32,
  parameter int N     = 56
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             finish,
  output logic [N-1:0]     quotient
);

  localparam int CW = $clog2(N);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     d_q, d_d;
  logic [WIDTH-1:0] m_q, m_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;
  logic             ge;

  // The remainder stays below the divisor, so its top bit is never shifted.
  logic unused_r;
  assign unused_r = r_q[WIDTH];

  assign r_sh  = {r_q[WIDTH-1:0], d_q[N-1]};
  assign r_sub = r_sh - {1'b0, m_q};
  assign ge    = (r_sh >= {1'b0, m_q});

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    m_d    = m_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(N - 1);
      r_d    = '0;
      q_d    = '0;
      d_d    = dividend;
      m_d    = divisor;
    end else if (busy_q) begin
      r_d = ge ? r_sub : r_sh;
      q_d = {q_q[N-2:0], ge};
      d_d = {d_q[N-2:0], 1'b0};
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      m_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      m_q    <= m_d;
    end
  end

  assign busy     = busy_q;
  assign finish   = busy_q && (cnt_q == '0);
  assign quotient = q_q;

endmodule

// File: rtl/fixed_p_std_sdiv_pipe.sv
// Sequential signed fixed-point divider with go/done handshake.
// Ports: go/left/right start an op; out holds the quotient; done pulses once.
module fixed_p_std_sdiv_pipe
  import fixed_p_div_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             done
);

  localparam int N = WIDTH + FRACT_WIDTH;

  if (WIDTH != INT_WIDTH + FRACT_WIDTH || WIDTH >= ABS_W) begin : g_bad_cfg
    $error("fixed_p_std_sdiv_pipe: bad WIDTH/INT_WIDTH/FRACT_WIDTH");
  end

  state_t           state_q, state_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;

  logic [ABS_W-1:0] l_abs, r_abs;
  logic [WIDTH-1:0] mag_l, mag_r;
  logic [N-1:0]     quo;
  logic [WIDTH-1:0] q;
  logic             start;
  logic             core_busy;
  logic             core_fin;

  assign l_abs = abs_u(ABS_W'(signed'(left)));
  assign r_abs = abs_u(ABS_W'(signed'(right)));
  assign mag_l = l_abs[WIDTH-1:0];
  assign mag_r = r_abs[WIDTH-1:0];
  assign start = (state_q == IDLE) && go;

  // Overflowing quotients wrap: only the low WIDTH bits are kept.
  assign q = quo[WIDTH-1:0];

  logic unused_ok;
  assign unused_ok = ^{l_abs[ABS_W-1:WIDTH], r_abs[ABS_W-1:WIDTH],
                       quo[N-1:WIDTH], core_busy};

  fixed_p_std_udiv_core #(
    .WIDTH(WIDTH),
    .N    (N)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dividend({mag_l, {FRACT_WIDTH{1'b0}}}),
    .divisor (mag_r),
    .busy    (core_busy),
    .finish  (core_fin),
    .quotient(quo)
  );

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = RUN;
          neg_d   = left[WIDTH-1] ^ right[WIDTH-1];
          dz_d    = (right == '0);
        end
      end
      RUN: begin
        if (core_fin) state_d = FINISH;
      end
      FINISH: begin
        out_d   = dz_q ? '0 : (neg_q ? -q : q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_fixed_p_std_sdiv_pipe.sv
// Scoreboard bench for the sequential signed fixed-point divider.
// Expected quotients are queued at go and compared when done pulses.
module tb_fixed_p_std_sdiv_pipe;

  localparam int LAT = 57;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] out;
  logic        done;

  always #5 clk = ~clk;

  fixed_p_std_sdiv_pipe #(
    .WIDTH      (32),
    .INT_WIDTH  (8),
    .FRACT_WIDTH(24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .go   (go),
    .left (left),
    .right(right),
    .out  (out),
    .done (done)
  );

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] l,
                                        input logic [31:0] r);
    longint sl;
    longint sr;
    longint qq;
    if (r == 32'h0) return 32'h0;
    sl = longint'($signed(l));
    sr = longint'($signed(r));
    qq = (sl * 64'sd16777216) / sr;
    return qq[31:0];
  endfunction

  always @(posedge clk) begin
    #1;
    if (prev_done) chk("done_pulse", 32'(done), 32'h0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", out, e.exp);
        chk("latency", 32'(cyc - e.acc), 32'(LAT));
      end
    end
    prev_done = done;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic launch(input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] exp);
    left  = l;
    right = r;
    go    = 1'b1;
    sb.push_back('{exp: exp, acc: cyc + 1});
    tick();
    go = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < LAT + 20) begin
      tick();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  task automatic op(input logic [31:0] l, input logic [31:0] r,
                    input logic [31:0] exp);
    launch(l, r, exp);
    drain();
  endtask

  logic [31:0] tl[6] = '{32'hFD00_0000, 32'hFD00_0000, 32'h0100_0000,
                         32'hFF00_0000, 32'h0500_0000, 32'h8000_0000};
  logic [31:0] tr[6] = '{32'h0180_0000, 32'hFE80_0000, 32'h0300_0000,
                         32'h0300_0000, 32'h0000_0000, 32'h0100_0000};
  logic [31:0] te[6] = '{32'hFE00_0000, 32'h0200_0000, 32'h0055_5555,
                         32'hFFAA_AAAB, 32'h0000_0000, 32'h8000_0000};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ka;
    logic [31:0] rl;
    logic [31:0] rr;
    reset = 1'b1;
    go    = 1'b0;
    left  = '0;
    right = '0;
    tick(3);
    chk("rst_out", out, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    tick();

    op(32'h0300_0000, 32'h0180_0000, 32'h0200_0000);
    tick(3);
    chk("out_held", out, 32'h0200_0000);

    for (int i = 0; i < 6; i++) op(tl[i], tr[i], te[i]);

    for (int i = 0; i < 8; i++) begin
      rl = $urandom;
      rr = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 32'h0400_0000));
      if (i == 3) rr = 32'hFFFF_FFFF;
      op(rl, rr, model(rl, rr));
    end

    launch(32'h0300_0000, 32'h0180_0000, 32'h0200_0000);
    tick(5);
    for (int i = 0; i < 10; i++) begin
      left  = $urandom;
      right = $urandom;
      go    = ~go;
      tick();
    end
    go = 1'b0;
    drain();
    tick(5);

    left  = 32'h0300_0000;
    right = 32'h0180_0000;
    go    = 1'b1;
    ka    = cyc + 1;
    sb.push_back('{exp: 32'h0200_0000, acc: ka});
    sb.push_back('{exp: 32'h0055_5555, acc: ka + LAT + 1});
    tick();
    left  = 32'h0100_0000;
    right = 32'h0300_0000;
    tick(LAT + 1);
    go = 1'b0;
    drain();

    launch(32'h0300_0000, 32'h0180_0000, 32'h0200_0000);
    tick(20);
    reset = 1'b1;
    sb.delete();
    tick();
    chk("abort_out", out, 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    reset = 1'b0;
    tick(LAT + 5);
    op(32'hFD00_0000, 32'h0180_0000, 32'hFE00_0000);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_p_std_sdiv_pipe.md
Name: fixed_p_std_sdiv_pipe

Overview:
- Multi-cycle signed fixed-point divider, drop-in sequential alternative to the combinational signed fixed-point divide primitive.
- Consumes two WIDTH-bit two's-complement operands in the same Q(INT_WIDTH).(FRACT_WIDTH) format and produces the quotient in that format.
- Uses the go/done handshake that Calyx sequential primitives use, so the compiler can schedule it like other pipelined arithmetic cells.
- Sits beside the signed add/sub/mult primitives and feeds their inputs in datapath groups.

Parameters:
WIDTH, 32, total operand/result width
INT_WIDTH, 8, integer bits including sign
FRACT_WIDTH, 24, fractional bits; WIDTH = INT_WIDTH + FRACT_WIDTH (elaboration-time assertion)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
go  input  1  start request; sampled only in IDLE
left  input  WIDTH  signed dividend, sampled on accepted go
right  input  WIDTH  signed divisor, sampled on accepted go
out  output  WIDTH  signed quotient; held until the next accepted go
done  output  1  one-cycle pulse when out is valid

Behaviour:
- Reset values: state=IDLE, out=0, done=0, all internal registers 0.
- Reset asserted in any state, including mid-RUN, aborts the operation next edge. done is not raised for the aborted operation. out returns to 0.
- States: IDLE, RUN, FINISH.
- IDLE -> RUN when go=1:
  - Latch mag_l=|left| and mag_r=|right| as WIDTH-bit unsigned values, so the most-negative input maps to 2^(WIDTH-1) without overflow.
  - Latch neg = left[WIDTH-1] ^ right[WIDTH-1].
  - Latch dz = (right==0).
  - Load counter = N-1, where N = WIDTH+FRACT_WIDTH.
- RUN: restoring long division, one quotient bit per cycle, MSB first.
  - Dividend D = mag_l << FRACT_WIDTH (N bits).
  - Each cycle: partial remainder R = {R, next bit of D}. If R >= mag_r, then R -= mag_r and the quotient bit is 1.
  - R is WIDTH+1 bits.
  - RUN -> FINISH when counter==0; otherwise decrement the counter.
- FINISH:
  - q = low WIDTH bits of the N-bit unsigned quotient, i.e. truncation toward zero with wrap on overflow; no saturation.
  - out <= dz ? 0 : (neg ? -q : q).
  - done=1 for this cycle only. Next state is IDLE.
- Latency: go accepted at edge k gives done=1 during the cycle after edge k+N+1, i.e. N+1 cycles after the go edge. Latency is fixed and independent of operand values, including divide-by-zero.
- go while RUN/FINISH is ignored; operands are not re-sampled.
- go held high through done restarts in the next cycle with fresh operands. The controller deasserts go after done, as with other Calyx sequential cells.
- left and right may change after acceptance without effect.
- Divide-by-zero: out=0, full latency, no error port.
- Negative results that truncate to 0 give 0, never -0 garbage; negating 0 yields 0.

Decomposition:
- Package fixed_p_div_pkg:
  - State typedef (enum IDLE/RUN/FINISH).
  - Helper function for absolute value of a WIDTH-bit signed value, returned as unsigned.
- Sub-module fixed_p_std_udiv_core:
  - Unsigned restoring-division iteration: R/Q/counter registers plus one subtract-compare per cycle.
  - Parameterised on WIDTH and N, with start/busy/finish signals.
- The top module owns sign handling, the FSM, the output register and done.

Test Plan (WIDTH=32, INT_WIDTH=8, FRACT_WIDTH=24, N=56):
- left=0x0300_0000 (3.0), right=0x0180_0000 (1.5), pulse go -> done exactly 57 cycles after the go edge, out=0x0200_0000 (2.0), done high 1 cycle, out held afterwards.
- left=0xFD00_0000 (-3.0), right=0x0180_0000 -> out=0xFE00_0000 (-2.0); left=0xFD00_0000, right=0xFE80_0000 (-1.5) -> out=0x0200_0000.
- left=0x0100_0000, right=0x0300_0000 -> out=0x0055_5555; left=0xFF00_0000, same right -> out=0xFFAA_AAAB (truncation toward zero).
- right=0, left=0x0500_0000 -> out=0, done after 57 cycles. Then left=0x8000_0000 (-128.0), right=0x0100_0000 -> out=0x8000_0000.
- Start 3.0/1.5, change left/right and toggle go during RUN -> result still 0x0200_0000, one done pulse only. Hold go high through done -> second operation begins the next cycle with the new operands.
- Assert reset 20 cycles into RUN -> out=0 and done=0 next edge, no done for the aborted operation. A fresh go after reset completes normally with the correct value.
